uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first. Recovers bytes from the serial line driven by
//  the team's uart_tx. Idle-high line, start bit 0, stop bit 1. Runs on an
//  oversampling clock and samples mid-bit. Emits each received byte with a
//  1-cycle valid strobe, and flags framing errors.
// PARAMETERS
//  OVERSAMPLE   16  i_clk_rx ticks per bit; even, >=4
//  SYNC_STAGES  2   flip-flops in the i_rxd synchronizer; >=2
// PORTS
//  i_clk_rx      in   1  sampling clock = OVERSAMPLE x baud
//  i_reset       in   1  asynchronous, active-high reset
//  i_rxd         in   1  serial line, asynchronous to i_clk_rx
//  o_data        out  8  last received byte; held until the next frame completes
//  o_valid       out  1  1-cycle pulse: o_data updated, good stop bit
//  o_frame_err   out  1  1-cycle pulse: stop bit sampled as 0
//  o_busy        out  1  high in every state except IDLE
//  o_parity_err  out  1  exists only with UART_RX_PARITY_EN; 1-cycle pulse
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, counters 0, synchronizer chain set to 1.
//    Reset mid-frame abandons the frame. No strobe fires for the abandoned frame.
//  - rxd_s is i_rxd after SYNC_STAGES flops. All decisions use rxd_s.
//  - tick: a counter that runs 0..OVERSAMPLE-1. It is cleared on every state entry.
//  - IDLE: if rxd_s==0, go to START and set tick=0.
//  - START: when tick==OVERSAMPLE/2-1, sample rxd_s (mid start bit).
//      0 -> go to DATA, with tick=0 and bit_cnt=0.
//      1 -> glitch; return to IDLE. No output activity.
//  - DATA: when tick==OVERSAMPLE-1, sample rxd_s into shift[bit_cnt] (LSB first)
//    and increment bit_cnt. After bit_cnt reaches 7 and is sampled, go to STOP
//    (or to PARITY with the macro).
//  - STOP: when tick==OVERSAMPLE-1, sample rxd_s.
//      1 -> on the next edge: o_data<=shift, o_valid=1 for 1 cycle; go to IDLE.
//      0 -> o_frame_err=1 for 1 cycle; o_data is NOT updated; go to BREAK.
//  - BREAK: wait for rxd_s==1, then go to IDLE. A held-low line gives a single
//    error and no retriggering.
//  - o_valid and o_frame_err are never high in the same cycle. Each fires at
//    most once per frame.
//  - Latency: o_valid rises OVERSAMPLE/2 + 9*OVERSAMPLE + 1 ticks after rxd_s
//    first reads 0. Add SYNC_STAGES for the latency from i_rxd.
//  - Back-to-back frames: a start bit arriving the tick after STOP returns to
//    IDLE is accepted. No gap is needed beyond the stop bit.
//  - Widths: tick is $clog2(OVERSAMPLE) bits; bit_cnt is 3 bits (wraps only
//    through the state change).
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Adds a PARITY state between DATA and STOP.
//    - Samples 1 even-parity bit at tick==OVERSAMPLE-1.
//    - Frame becomes 8E1.
//    - In STOP with a good stop bit, o_valid fires regardless of parity.
//      o_parity_err pulses in the same cycle if ^{shift,parity}!=0.
//    - o_data is still updated.
//    - Latency grows by OVERSAMPLE.
//  Undefined:
//    - No PARITY state; 8N1.
//    - o_parity_err port is absent.
// TESTING (OVERSAMPLE=16, 16 ticks/bit)
//  1 Send 0xA5 8N1 -> one o_valid pulse, o_data=8'hA5, o_frame_err=0,
//    o_busy low afterwards.
//  2 Send 0x00, then 0xFF back-to-back, no idle gap -> two o_valid pulses,
//    o_data 8'h00 then 8'hFF.
//  3 Drive i_rxd low for 5 ticks, then high -> returns to IDLE, no o_valid,
//    no o_frame_err.
//  4 Send 0x3C with stop bit 0, then hold the line low for 40 bit times ->
//    exactly one o_frame_err pulse, o_data unchanged. A following good 0x81
//    frame gives o_valid with o_data=8'h81.
//  5 Assert i_reset after bit d3 of 0x5A, release it, then send 0x12 ->
//    no strobe for 0x5A; o_valid with o_data=8'h12.
//  6 With UART_RX_PARITY_EN: send 0x07 with parity 1 -> o_valid,
//    o_parity_err=0. Send 0x07 with parity 0 -> o_valid and o_parity_err
//    in the same cycle.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an OVERSAMPLE x baud clock, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with an o_parity_err strobe.
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk_rx,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  state_e                 state_q, state_d;
  logic [TickW-1:0]       tick_q, tick_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_q, parity_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // Chain resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge i_clk_rx or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rxd};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk_rx or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = (tick_q == TickLast) ? '0 : tick_q + TickW'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d     = parity_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxd_s) state_d = StStart;
      end
      StStart: begin
        if (tick_q == TickMid) begin
          if (rxd_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (tick_q == TickLast) begin
          shift_d[bit_cnt_q] = rxd_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick_q == TickLast) begin
          parity_d = rxd_s;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        if (tick_q == TickLast) begin
          if (rxd_s) begin
            data_d       = shift_q;
            valid_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ^{shift_q, parity_q};
`endif
            state_d      = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxd_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Every state entry restarts the bit timer; IDLE keeps it parked at zero.
    if (state_d != state_q || state_q == StIdle) tick_d = '0;
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, corner sequences, random frames vs a frame model.
module tb_uart_rx;

  localparam int unsigned OS   = 16;
  localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Cycles from driving the start edge to the o_valid/o_frame_err strobe.
  localparam int LATENCY = OS / 2 + (9 + PAR_BITS) * OS + 1 + SYNC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, busy, perr;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
    .i_clk_rx    (clk),
    .i_reset     (rst),
    .i_rxd       (rxd),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
`ifdef UART_RX_PARITY_EN
    .o_busy      (busy),
    .o_parity_err(perr)
`else
    .o_busy      (busy)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         both_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         last_drop = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid || ferr) begin
      ev_t e;
      e.ferr = ferr;
      e.data = data;
      e.perr = perr;
      e.cyc  = cyc;
      obs_q.push_back(e);
    end
    if (valid && ferr) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    last_drop = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("note: unknown parity argument");
`endif
    send_bit(stop);
  endtask

  // Frame-level model: good stop delivers the byte, bad stop flags an error and keeps o_data.
  function automatic ev_t model(input logic [7:0] d, input logic stop, input logic par);
    ev_t e;
    e.ferr = !stop;
    e.data = stop ? d : last_good;
`ifdef UART_RX_PARITY_EN
    e.perr = stop && ((^d) != par);
`else
    e.perr = 1'b0;
`endif
    e.cyc  = last_drop + LATENCY;
    if (stop) last_good = d;
    return e;
  endfunction

  task automatic compare_events(input string name);
    #1;
    check({name, " count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check({name, " frame_err"}, obs_q[i].ferr, exp_q[i].ferr);
      check({name, " data"}, obs_q[i].data, exp_q[i].data);
      check({name, " parity_err"}, obs_q[i].perr, exp_q[i].perr);
      check({name, " strobe cycle"}, obs_q[i].cyc, exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};
    vecs[3] = '{8'h01, 1'b1, 1, 1'b0, 8'h01};
    vecs[4] = '{8'h80, 1'b1, 0, 1'b0, 8'h80};
    vecs[5] = '{8'hC3, 1'b1, 3, 1'b0, 8'hC3};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset data", data, 8'h00);
    check("reset valid", valid, 1'b0);
    check("reset frame_err", ferr, 1'b0);
    check("reset busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post-reset busy", busy, 1'b0);
    repeat (OS) @(negedge clk);
    compare_events("post-reset idle");

    // Table vectors, including back-to-back frames
    for (int v = 0; v < 6; v++) begin
      ev_t e;
      send_frame(vecs[v].data, vecs[v].stop, ^vecs[v].data);
      e.ferr = vecs[v].exp_ferr;
      e.data = vecs[v].exp_data;
      e.perr = 1'b0;
      e.cyc  = last_drop + LATENCY;
      exp_q.push_back(e);
      if (!vecs[v].exp_ferr) last_good = vecs[v].exp_data;
      repeat (vecs[v].gap * OS) @(negedge clk);
      compare_events($sformatf("vec%0d", v));
      if (vecs[v].gap > 0) check($sformatf("vec%0d busy after", v), busy, 1'b0);
    end

    // Start glitch shorter than half a bit
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch busy", busy, 1'b1);
    @(negedge clk);
    rxd = 1'b1;
    repeat (2 * OS) @(negedge clk);
    compare_events("glitch");
    check("glitch busy after", busy, 1'b0);

    // Bad stop then long break, then a good frame
    send_frame(8'h3C, 1'b0, ^8'h3C);
    exp_q.push_back(model(8'h3C, 1'b0, ^8'h3C));
    repeat (40 * OS) @(negedge clk);
    check("break busy", busy, 1'b1);
    rxd = 1'b1;
    repeat (OS) @(negedge clk);
    compare_events("break");
    check("break data held", data, last_good);
    check("break busy after", busy, 1'b0);
    send_frame(8'h81, 1'b1, ^8'h81);
    exp_q.push_back(model(8'h81, 1'b1, ^8'h81));
    repeat (2 * OS) @(negedge clk);
    compare_events("after break");

    // Reset mid-frame after d3 of 0x5A
    last_drop = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid reset data", data, 8'h00);
    check("mid reset busy", busy, 1'b0);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (2 * OS) @(negedge clk);
    compare_events("abandoned frame");
    send_frame(8'h12, 1'b1, ^8'h12);
    exp_q.push_back(model(8'h12, 1'b1, ^8'h12));
    repeat (2 * OS) @(negedge clk);
    compare_events("after reset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(model(8'h07, 1'b1, 1'b1));
    repeat (2 * OS) @(negedge clk);
    compare_events("parity good");
    send_frame(8'h07, 1'b1, 1'b0);
    exp_q.push_back(model(8'h07, 1'b1, 1'b0));
    repeat (2 * OS) @(negedge clk);
    compare_events("parity bad");
`endif

    // Random frames against the model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       stop, par;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      gap  = stop ? int'($urandom_range(0, 2)) : 1;
      send_frame(d, stop, par);
      exp_q.push_back(model(d, stop, par));
      rxd = 1'b1;
      repeat (gap * OS) @(negedge clk);
      compare_events($sformatf("rand%0d", n));
    end

    check("valid and frame_err overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
